fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter data_width, default 6, giving the width of each requester word and of the FIFO write word.
REQ-002 The block SHALL have parameter num_req, default 4, giving the number of requesters; requester index width is 2.
REQ-003 The block SHALL have parameter max_burst, default 4, giving the maximum number of words written per grant.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  num_req  per-requester write request, held high while the requester has data.
- req_data  in  num_req*data_width  packed requester words; requester i occupies bits [i*data_width +: data_width].
- full  in  1  FIFO full flag from the shared FIFO write port.
- grant  out  num_req  one-hot registered grant; all-zero when no requester is granted.
- write_enable  out  1  FIFO write strobe.
- write_data  out  data_width  FIFO write word.
- active_id  out  2  index of the granted requester; 0 when idle.
- busy  out  1  high while in SERVE.

Function
REQ-005 The block SHALL implement a two-state machine: IDLE and SERVE.
REQ-006 In IDLE with req nonzero, the block SHALL select the first requester with req high, searching from rr_ptr upward modulo num_req.
REQ-007 On the same edge, the block SHALL register the one-hot grant, set active_id, clear beat_cnt and enter SERVE; grant is visible one cycle after req is sampled.
REQ-008 In IDLE with req zero, the block SHALL stay in IDLE with grant zero.
REQ-009 write_enable SHALL be combinational and equal (state==SERVE) & req[active_id] & !full.
REQ-010 write_data SHALL be combinational and equal the req_data slice of active_id.
REQ-011 On each cycle with write_enable high, the block SHALL increment beat_cnt, a counter of width clog2(max_burst)+1.
REQ-012 While full is high in SERVE, the block SHALL stall: grant, active_id and beat_cnt hold, write_enable is 0, and no burst termination occurs.
REQ-013 The block SHALL leave SERVE for IDLE on the edge where either of these holds:
- write_enable is high and beat_cnt == max_burst-1 (burst limit reached), or
- req[active_id] is low (requester withdrew).
REQ-014 On leaving SERVE, the block SHALL set rr_ptr to (active_id+1) mod num_req, clear grant to zero and clear busy.
REQ-015 After leaving SERVE, the block SHALL spend at least one cycle in IDLE before the next grant; this bubble cycle has write_enable 0.
REQ-016 If other requesters change req while one is granted, the grant SHALL be unaffected; those requests are considered only at the next arbitration.
REQ-017 When req is high and full is high together, the requester SHALL keep the grant for as long as the stall lasts, with no timeout.
REQ-018 The block SHALL write at most max_burst words per grant and never more than one word per cycle.
REQ-019 The block SHALL never assert write_enable while full is high.

Reset
REQ-020 While reset is high, the block SHALL force asynchronously: state=IDLE, grant=0, active_id=0, beat_cnt=0, rr_ptr=0, busy=0, and therefore write_enable=0.
REQ-021 If reset is asserted mid-burst, the burst SHALL be abandoned with no further write.
REQ-022 After reset deasserts, arbitration SHALL restart from requester 0.

Verification
REQ-023 Single requester: req=4'b0010, full=0, steady data 6'h15 -> grant=4'b0010 one cycle later; 4 consecutive writes of 6'h15; then one IDLE bubble; then a fresh 4-write burst.
REQ-024 Round-robin fairness: req=4'b1111 held, full=0 -> grant order 0,1,2,3,0 with 4 writes each and a 1-cycle bubble between grants.
REQ-025 Backpressure: requester 2 granted, full held high for 3 cycles after the 2nd write -> write_enable=0 for those 3 cycles, beat_cnt holds at 2, the remaining 2 writes follow when full drops, total 4.
REQ-026 Early withdraw: requester 1 drops req after 2 writes -> SERVE exits, rr_ptr=2, and the next grant goes to the next requesting index at or after 2.
REQ-027 Reset mid-burst: assert reset after the 1st write of requester 3 -> grant, busy and write_enable go to 0 immediately; after release with req=4'b1000, the grant goes to requester 3 and arbitration starts from rr_ptr=0.
REQ-028 The bench SHALL check, every cycle, that write_enable & full is never 1, that grant is one-hot or zero, and that writes per grant are at most 4.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that hands a shared FIFO write port to one requester
// at a time, for bursts of up to max_burst words, stalling on FIFO full.
module fifo_write_arbiter #(
  parameter int data_width = 6,
  parameter int num_req    = 4,
  parameter int max_burst  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [num_req-1:0]            req,
  input  logic [num_req*data_width-1:0] req_data,
  input  logic                          full,
  output logic [num_req-1:0]            grant,
  output logic                          write_enable,
  output logic [data_width-1:0]         write_data,
  output logic [1:0]                    active_id,
  output logic                          busy
);

  localparam int cnt_w = $clog2(max_burst) + 1;

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_e;

  // Handshake: a word is transferred on every cycle write_enable is high;
  // full is the FIFO's ready (inverted) and is never overridden.
  state_e             state_q, state_d;
  logic [num_req-1:0] grant_q, grant_d;
  logic [1:0]         active_id_q, active_id_d;
  logic [cnt_w-1:0]   beat_q, beat_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         pick_idx;
  logic [1:0]         cand;
  logic               burst_done;

  // Lowest offset from rr_ptr wins, so scan offsets from highest to lowest.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    for (int k = num_req - 1; k >= 0; k--) begin
      cand = 2'((int'(rr_ptr_q) + k) % num_req);
      if (req[cand]) pick_idx = cand;
    end
  end

  assign write_enable = (state_q == SERVE) & req[active_id_q] & ~full;
  assign write_data   = req_data[int'(active_id_q)*data_width +: data_width];
  assign burst_done   = write_enable && (beat_q == cnt_w'(max_burst - 1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    active_id_d = active_id_q;
    beat_d      = beat_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|req) begin
          state_d     = SERVE;
          grant_d     = num_req'(1) << pick_idx;
          active_id_d = pick_idx;
          beat_d      = '0;
        end
      end
      SERVE: begin
        if (!req[active_id_q] || burst_done) begin
          state_d     = IDLE;
          grant_d     = '0;
          active_id_d = '0;
          rr_ptr_d    = 2'((int'(active_id_q) + 1) % num_req);
        end else if (write_enable) begin
          beat_d = beat_q + cnt_w'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      active_id_q <= '0;
      beat_q      <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      active_id_q <= active_id_d;
      beat_q      <= beat_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign grant     = grant_q;
  assign active_id = active_id_q;
  assign busy      = (state_q == SERVE);

endmodule
